// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared constants and state encoding for the fabric configuration loader
//
// Purpose : frame geometry defaults, sync marker, word width and the loader
//           state enumeration, shared by the loader and its bench.
// Ports   : none (package).

package cfg_pkg;

  localparam int          WORD_W    = 32;
  localparam int          N_LUT     = 11;
  localparam int          N_SB      = 20;
  // LUT words, then switch-box words, then one FF-select word per tile
  localparam int          TOTAL     = 2 * N_LUT + N_SB;
  localparam logic [31:0] SYNC_WORD = 32'hA5C3_0F1E;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } cfg_state_e;

endpackage

// File: rtl/config_loader.sv
// rtl/config_loader.sv - bitstream frame loader for LUT tiles and switch boxes
//
// Purpose : hunts for SYNC_WORD, loads a TOTAL-word frame into the LUT truth
//           tables, switch-box configuration and FF-select bits, then checks
//           an XOR checksum word before enabling the fabric.
// Ports   :
//   clock       in   1          rising-edge clock
//   reset       in   1          synchronous active-high reset
//   cfg_data    in   32         bitstream word
//   cfg_valid   in   1          cfg_data valid
//   cfg_ready   out  1          loader accepts a word (IDLE/LOAD/CHECK)
//   lut_mem     out  N_LUT*33   tile k at [k*33 +: 33]; [31:0] truth table, [32] FF-select
//   sb_conf     out  N_SB*32    switch box k at [k*32 +: 32]
//   fabric_en   out  1          configuration valid, fabric may run
//   load_done   out  1          frame accepted
//   load_error  out  1          checksum mismatch

module config_loader #(
  parameter int          N_LUT     = cfg_pkg::N_LUT,
  parameter int          N_SB      = cfg_pkg::N_SB,
  parameter logic [31:0] SYNC_WORD = cfg_pkg::SYNC_WORD
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [N_LUT*33-1:0]  lut_mem,
  output logic [N_SB*32-1:0]   sb_conf,
  output logic                 fabric_en,
  output logic                 load_done,
  output logic                 load_error
);

  import cfg_pkg::*;

  localparam int         FRAME_LEN = 2 * N_LUT + N_SB;
  localparam logic [5:0] IDX_LAST  = 6'(FRAME_LEN - 1);

  cfg_state_e            state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [WORD_W-1:0]     csum_q, csum_d;
  logic [N_LUT*33-1:0]   lut_q, lut_d;
  logic [N_SB*32-1:0]    sb_q, sb_d;
  logic                  ready_q, ready_d;
  logic                  fabric_en_q, fabric_en_d;
  logic                  load_done_q, load_done_d;
  logic                  load_error_q, load_error_d;
  logic                  xfer;

  // ready is a register, so a transfer is judged against the registered value
  assign xfer = cfg_valid && ready_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    csum_d       = csum_q;
    lut_d        = lut_q;
    sb_d         = sb_q;
    ready_d      = ready_q;
    fabric_en_d  = fabric_en_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;

    case (state_q)
      ST_IDLE: begin
        // anything before the marker is line noise and is dropped
        if (xfer && cfg_data == SYNC_WORD) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          csum_d  = '0;
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          // SYNC_WORD is ordinary data here; only the index decides placement
          csum_d = csum_q ^ cfg_data;
          for (int k = 0; k < N_LUT; k++) begin
            if (idx_q == 6'(k)) begin
              lut_d[k*33 +: 32] = cfg_data;
            end
          end
          for (int k = 0; k < N_SB; k++) begin
            if (idx_q == 6'(N_LUT + k)) begin
              sb_d[k*32 +: 32] = cfg_data;
            end
          end
          // tail words carry only the FF-select bit for each tile
          for (int k = 0; k < N_LUT; k++) begin
            if (idx_q == 6'(N_LUT + N_SB + k)) begin
              lut_d[k*33 + 32] = cfg_data[0];
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      ST_CHECK: begin
        if (xfer) begin
          ready_d = 1'b0;
          if (cfg_data == csum_q) begin
            state_d     = ST_DONE;
            fabric_en_d = 1'b1;
            load_done_d = 1'b1;
          end else begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
          end
        end
      end

      // terminal states: only reset leaves them
      ST_DONE, ST_ERROR: begin
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      csum_q       <= '0;
      lut_q        <= '0;
      sb_q         <= '0;
      ready_q      <= 1'b1;
      fabric_en_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      lut_q        <= lut_d;
      sb_q         <= sb_d;
      ready_q      <= ready_d;
      fabric_en_q  <= fabric_en_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign lut_mem    = lut_q;
  assign sb_conf    = sb_q;
  assign fabric_en  = fabric_en_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - directed, table-driven bench for config_loader

module tb_config_loader;

  import cfg_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [31:0]          cfg_data;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [N_LUT*33-1:0]  lut_mem;
  logic [N_SB*32-1:0]   sb_conf;
  logic                 fabric_en;
  logic                 load_done;
  logic                 load_error;

  int errors = 0;
  int checks = 0;

  config_loader dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .lut_mem    (lut_mem),
    .sb_conf    (sb_conf),
    .fabric_en  (fabric_en),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          junk;
    bit          toggle;
    logic [31:0] w0;
    logic [31:0] w11;
    logic [31:0] w31;
    logic [31:0] csum;
    bit          exp_ok;
  } vec_t;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit with_valid, input logic [31:0] data);
    @(negedge clock);
    reset     = 1'b1;
    cfg_valid = with_valid;
    cfg_data  = data;
    @(negedge clock);
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
  endtask

  task automatic send(input logic [31:0] w, input bit toggle);
    int waits;
    if (toggle) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        cfg_valid = 1'b0;
        cfg_data  = $urandom;
      end
    end
    @(negedge clock);
    cfg_data  = w;
    cfg_valid = 1'b1;
    waits     = 0;
    while (!cfg_ready && waits < 16) begin
      @(negedge clock);
      waits++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cfg_ready stayed 0 for word %h", w);
    end
    @(posedge clock);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_body(input logic [31:0] w0, input logic [31:0] w11,
                           input logic [31:0] w31, input bit toggle);
    logic [31:0] w;
    send(SYNC_WORD, toggle);
    for (int i = 0; i < TOTAL; i++) begin
      w = (i == 0) ? w0 : (i == 11) ? w11 : (i == 31) ? w31 : 32'h0;
      send(w, toggle);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    @(negedge clock);
    chk({tag, "_ready"},  1024'(cfg_ready),  1024'(1'b1));
    chk({tag, "_fabric"}, 1024'(fabric_en),  1024'(1'b0));
    chk({tag, "_done"},   1024'(load_done),  1024'(1'b0));
    chk({tag, "_error"},  1024'(load_error), 1024'(1'b0));
    chk({tag, "_lut"},    1024'(lut_mem),    1024'(0));
    chk({tag, "_sb"},     1024'(sb_conf),    1024'(0));
  endtask

  vec_t vecs[6];

  initial begin
    logic [N_LUT*33-1:0] exp_lut;
    logic [N_SB*32-1:0]  exp_sb;

    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;

    vecs[0] = '{"zeros",   1'b0, 1'b0, 32'h0,         32'h0,        32'h0,        32'h0,        1'b1};
    vecs[1] = '{"basic",   1'b0, 1'b0, 32'hFFFF0000,  32'h0000FFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    vecs[2] = '{"badsum",  1'b0, 1'b0, 32'hFFFF0000,  32'h0000FFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[3] = '{"junk",    1'b1, 1'b0, 32'hFFFF0000,  32'h0000FFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    vecs[4] = '{"toggle",  1'b0, 1'b1, 32'hFFFF0000,  32'h0000FFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    vecs[5] = '{"syncdat", 1'b0, 1'b0, 32'hA5C30F1E,  32'h0,        32'hFFFFFFFE, 32'h5A3CF0E0, 1'b1};

    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0, 32'h0);
      chk_reset_state({vecs[v].name, "_rst"});

      if (vecs[v].junk) begin
        send(32'h12345678, 1'b0);
        send(32'hDEADBEEF, 1'b0);
      end
      send_body(vecs[v].w0, vecs[v].w11, vecs[v].w31, vecs[v].toggle);
      @(negedge clock);
      chk({vecs[v].name, "_pre_fabric"}, 1024'(fabric_en), 1024'(1'b0));
      chk({vecs[v].name, "_pre_ready"},  1024'(cfg_ready), 1024'(1'b1));

      send(vecs[v].csum, vecs[v].toggle);
      // the checksum edge has just passed; outputs must already reflect it
      chk({vecs[v].name, "_fabric"}, 1024'(fabric_en),  1024'(vecs[v].exp_ok));
      chk({vecs[v].name, "_done"},   1024'(load_done),  1024'(vecs[v].exp_ok));
      chk({vecs[v].name, "_error"},  1024'(load_error), 1024'(!vecs[v].exp_ok));
      chk({vecs[v].name, "_ready"},  1024'(cfg_ready),  1024'(1'b0));

      exp_lut          = '0;
      exp_lut[31:0]    = vecs[v].w0;
      exp_lut[32]      = vecs[v].w31[0];
      exp_sb           = '0;
      exp_sb[31:0]     = vecs[v].w11;
      chk({vecs[v].name, "_lut"}, 1024'(lut_mem), 1024'(exp_lut));
      chk({vecs[v].name, "_sb"},  1024'(sb_conf), 1024'(exp_sb));

      // terminal state must hold while words keep arriving
      cfg_valid = 1'b1;
      cfg_data  = SYNC_WORD;
      repeat (4) @(negedge clock);
      cfg_valid = 1'b0;
      chk({vecs[v].name, "_hold_fabric"}, 1024'(fabric_en),  1024'(vecs[v].exp_ok));
      chk({vecs[v].name, "_hold_error"},  1024'(load_error), 1024'(!vecs[v].exp_ok));
      chk({vecs[v].name, "_hold_lut"},    1024'(lut_mem),    1024'(exp_lut));
    end

    // reset in the middle of a frame, with a word presented on the reset edge
    do_reset(1'b0, 32'h0);
    send(SYNC_WORD, 1'b0);
    for (int i = 0; i <= 20; i++) begin
      send(32'(i + 1), 1'b0);
    end
    @(negedge clock);
    chk("mid_tile0", 1024'(lut_mem[31:0]), 1024'(32'h1));
    chk("mid_sb0",   1024'(sb_conf[31:0]), 1024'(32'd12));
    do_reset(1'b1, SYNC_WORD);
    chk_reset_state("mid_rst");

    // a non-SYNC word now must be ignored, proving the loader is back in IDLE
    send(32'h0000_0001, 1'b0);
    send_body(32'hFFFF0000, 32'h0000FFFF, 32'h00000001, 1'b0);
    send(32'hFFFFFFFE, 1'b0);
    chk("fresh_fabric", 1024'(fabric_en),      1024'(1'b1));
    chk("fresh_done",   1024'(load_done),      1024'(1'b1));
    chk("fresh_tile0",  1024'(lut_mem[32:0]),  1024'(33'h1_FFFF0000));
    chk("fresh_sb0",    1024'(sb_conf[31:0]),  1024'(32'h0000FFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter N_LUT, default 11, number of logic tiles.
REQ-002 The block SHALL have parameter N_SB, default 20, number of switch boxes.
REQ-003 The block SHALL have parameter SYNC_WORD, default 32'hA5C3_0F1E, frame start marker.
REQ-004 The block SHALL have port clock, input, 1, the only clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port cfg_data, input, 32, bitstream word.
REQ-007 The block SHALL have port cfg_valid, input, 1, cfg_data valid.
REQ-008 The block SHALL have port cfg_ready, output, 1, block accepts a word.
REQ-009 The block SHALL have port lut_mem, output, N_LUT*33, tile k in bits [k*33 +: 33]; bits 31:0 are the LUT truth table and bit 32 is the FF-select bit.
REQ-010 The block SHALL have port sb_conf, output, N_SB*32, switch box k in bits [k*32 +: 32].
REQ-011 The block SHALL have port fabric_en, output, 1, configuration valid and fabric may run.
REQ-012 The block SHALL have port load_done, output, 1, frame accepted.
REQ-013 The block SHALL have port load_error, output, 1, checksum mismatch.

Function
REQ-014 A transfer SHALL occur on a rising clock edge where cfg_valid and cfg_ready are both 1; idle cycles SHALL change nothing.
REQ-015 States SHALL be IDLE, LOAD, CHECK, DONE and ERROR; cfg_ready SHALL be 1 in IDLE, LOAD and CHECK, and 0 in DONE and ERROR.
REQ-016 In IDLE, a transfer equal to SYNC_WORD SHALL move to LOAD with idx=0 and csum=0; any other word SHALL be discarded and the state SHALL stay IDLE.
REQ-017 In LOAD, the frame SHALL be TOTAL = 2*N_LUT+N_SB words (42 by default), indexed by a counter idx.
REQ-018 In LOAD, word idx < N_LUT SHALL be written to lut_mem tile idx bits 31:0.
REQ-019 In LOAD, word N_LUT <= idx < N_LUT+N_SB SHALL be written to sb_conf box idx-N_LUT.
REQ-020 In LOAD, the remaining words SHALL write their bit 0 to FF-select bit 32 of tile idx-N_LUT-N_SB; all other bits of those words SHALL be ignored for configuration.
REQ-021 Every LOAD transfer SHALL update csum <= csum XOR cfg_data, using the full 32 bits.
REQ-022 A word equal to SYNC_WORD received during LOAD SHALL be treated as ordinary data.
REQ-023 The transfer at idx=TOTAL-1 SHALL move the state to CHECK.
REQ-024 In CHECK, the next transfer SHALL be compared with csum: on a match go to DONE, on a mismatch go to ERROR.
REQ-025 In DONE, fabric_en and load_done SHALL be 1 starting the cycle after the checksum transfer.
REQ-026 In ERROR, load_error SHALL be 1, fabric_en SHALL be 0, and lut_mem/sb_conf SHALL keep their written values.
REQ-027 fabric_en SHALL be 0 in every state except DONE.
REQ-028 DONE and ERROR SHALL be left only by reset.
REQ-029 All outputs SHALL be registered; configuration registers SHALL update one cycle after their transfer.

Reset
REQ-030 When reset=1 at a clock edge, the block SHALL set state=IDLE, idx=0, csum=0, lut_mem=0, sb_conf=0, fabric_en=0, load_done=0, load_error=0 and cfg_ready=1, including when reset occurs in the middle of a load.
REQ-031 reset SHALL take priority over a simultaneous transfer; that word SHALL be dropped.

Structure
REQ-032 The shared package cfg_pkg SHALL hold N_LUT, N_SB, TOTAL, SYNC_WORD, the word width of 32 and the state enumeration.
REQ-033 The block SHALL be a single module with no sub-module; idx SHALL be 6 bits wide.

Verification
REQ-034 The bench SHALL send SYNC, then 42 words of 0, then checksum 0, and SHALL see fabric_en=1 and load_done=1 one cycle later with all configuration bits 0.
REQ-035 The bench SHALL send SYNC; word0=FFFF0000; word11=0000FFFF; word31=00000001; all other words 0; checksum FFFFFFFE. It SHALL see lut_mem tile0[31:0]=FFFF0000, sb_conf box0=0000FFFF, tile0 bit32=1, and fabric_en=1.
REQ-036 The bench SHALL send the same frame with checksum 00000000 and SHALL see load_error=1, fabric_en=0, cfg_ready=0.
REQ-037 The bench SHALL send 12345678 and DEADBEEF before SYNC, then a valid frame, and SHALL see the pre-SYNC words ignored and a normal load.
REQ-038 The bench SHALL assert reset after word 20 of a frame and SHALL see all outputs 0 and state IDLE; a fresh valid frame SHALL then load correctly.
REQ-039 The bench SHALL toggle cfg_valid randomly across a valid frame and SHALL see results identical to REQ-035.
